// File: rtl/dp_ram_sc_bw.sv
// dp_ram_sc_bw: single-clock true dual-port RAM with per-byte write enables,
// a fixed collision policy, an optional output register and a post-reset
// clear sequencer. The control pins are active low to match the SRAM macros.
//
// Ports
//   CLK                  rising-edge clock shared by both ports
//   RST                  asynchronous active-high reset (control and read path)
//   A_A / A_B            word address per port
//   DI_A / DI_B          write data per port
//   CE_N_A / CE_N_B      port enable (active low)
//   GWE_N_A / GWE_N_B    global write enable (active low); high means read
//   BWE_N_A / BWE_N_B    byte-lane write enables (active low)
//   OE_N_A / OE_N_B      combinational output gate (active low)
//   DO_A / DO_B          read data, forced to 0 while OE_N is high
//   INIT_BUSY            clear sequence in progress, ports ignored
//   COLL                 one-cycle pulse after a same-address access with a write
module dp_ram_sc_bw #(
  parameter int DW         = 32,
  parameter int AW         = 9,
  parameter int BW         = 8,
  parameter int RD_MODE    = 0,
  parameter int OUT_REG    = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [AW-1:0]       A_A,
  input  logic [AW-1:0]       A_B,
  input  logic [DW-1:0]       DI_A,
  input  logic [DW-1:0]       DI_B,
  input  logic                CE_N_A,
  input  logic                CE_N_B,
  input  logic                GWE_N_A,
  input  logic                GWE_N_B,
  input  logic [DW/BW-1:0]    BWE_N_A,
  input  logic [DW/BW-1:0]    BWE_N_B,
  input  logic                OE_N_A,
  input  logic                OE_N_B,
  output logic [DW-1:0]       DO_A,
  output logic [DW-1:0]       DO_B,
  output logic                INIT_BUSY,
  output logic                COLL
);

  localparam int NB    = DW / BW;
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_READY} state_t;

  logic [DW-1:0] mem [DEPTH];

  state_t        state, state_nxt;
  logic [AW-1:0] clr_cnt, clr_cnt_nxt;
  logic          clr_we;

  logic          en_a, en_b, wr_a, wr_b, rden_a, rden_b;
  logic [NB-1:0] we_a, we_b;
  logic [DW-1:0] old_a, old_b, merged_a, merged_b;
  logic          coll_p0;

  logic [DW-1:0] rd_a_p1, rd_b_p1, rd_a_p2, rd_b_p2;
  logic          coll_p1;

  // New lanes where enabled, old lanes elsewhere.
  function automatic logic [DW-1:0] merge_lanes(input logic [DW-1:0] old_w,
                                                input logic [DW-1:0] new_w,
                                                input logic [NB-1:0] lane_we);
    logic [DW-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (lane_we[i]) res[i*BW +: BW] = new_w[i*BW +: BW];
    end
    return res;
  endfunction

  // Clear sequencer. The edge that leaves IDLE already writes word 0, so a
  // full clear takes exactly DEPTH edges after RST deasserts.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    clr_we      = 1'b0;
    case (state)
      S_IDLE, S_CLEAR: begin
        if (CLR_ON_RST != 0) begin
          // Gated by RST so that holding reset never touches the array.
          clr_we = !RST;
          if (clr_cnt == AW'(DEPTH - 1)) begin
            state_nxt = S_READY;
          end else begin
            state_nxt   = S_CLEAR;
            clr_cnt_nxt = clr_cnt + 1'b1;
          end
        end else begin
          state_nxt = S_READY;
        end
      end
      default: state_nxt = S_READY;
    endcase
  end

  assign INIT_BUSY = (CLR_ON_RST != 0) && (state != S_READY);

  // Port decode
  assign en_a   = !CE_N_A && !INIT_BUSY && !RST;
  assign en_b   = !CE_N_B && !INIT_BUSY && !RST;
  assign wr_a   = en_a && !GWE_N_A;
  assign wr_b   = en_b && !GWE_N_B;
  assign rden_a = en_a && GWE_N_A;
  assign rden_b = en_b && GWE_N_B;
  assign we_a   = {NB{wr_a}} & ~BWE_N_A;
  assign we_b   = {NB{wr_b}} & ~BWE_N_B;

  assign old_a    = mem[A_A];
  assign old_b    = mem[A_B];
  assign merged_a = merge_lanes(old_a, DI_A, we_a);
  assign merged_b = merge_lanes(old_b, DI_B, we_b);

  assign coll_p0 = en_a && en_b && (A_A == A_B) && (wr_a || wr_b);

  // Array update. Port A is applied last so it owns lanes both ports write.
  always_ff @(posedge CLK) begin
    if (clr_we) mem[clr_cnt] <= '0;
    for (int i = 0; i < NB; i++) begin
      if (we_b[i]) mem[A_B][i*BW +: BW] <= DI_B[i*BW +: BW];
      if (we_a[i]) mem[A_A][i*BW +: BW] <= DI_A[i*BW +: BW];
    end
  end

  // ---- stage p1: read registers and collision flag ----
  // A read always returns the pre-edge word, including against a write from
  // the other port. A write returns the old word (read-first, only when a
  // lane is enabled) or this port's merged word (write-first).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_a_p1 <= '0;
      rd_b_p1 <= '0;
      coll_p1 <= 1'b0;
    end else begin
      coll_p1 <= coll_p0;
      if (rden_a) begin
        rd_a_p1 <= old_a;
      end else if (wr_a) begin
        if (RD_MODE != 0)  rd_a_p1 <= merged_a;
        else if (|we_a)    rd_a_p1 <= old_a;
      end
      if (rden_b) begin
        rd_b_p1 <= old_b;
      end else if (wr_b) begin
        if (RD_MODE != 0)  rd_b_p1 <= merged_b;
        else if (|we_b)    rd_b_p1 <= old_b;
      end
    end
  end

  // ---- stage p2: optional output register, loads every cycle ----
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_a_p2 <= '0;
      rd_b_p2 <= '0;
    end else begin
      rd_a_p2 <= rd_a_p1;
      rd_b_p2 <= rd_b_p1;
    end
  end

  assign DO_A = OE_N_A ? '0 : ((OUT_REG != 0) ? rd_a_p2 : rd_a_p1);
  assign DO_B = OE_N_B ? '0 : ((OUT_REG != 0) ? rd_b_p2 : rd_b_p1);
  assign COLL = coll_p1;

endmodule

// File: tb/tb_dp_ram_sc_bw.sv
// Bench for dp_ram_sc_bw. Two instances share the stimulus:
//   u0: AW=9, read-first, no output register
//   u1: AW=4, write-first, output register (sees the low 4 address bits)
module tb_dp_ram_sc_bw;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  a_a, a_b;
  logic [31:0] di_a, di_b;
  logic        ce_n_a, ce_n_b, gwe_n_a, gwe_n_b, oe_n_a, oe_n_b;
  logic [3:0]  bwe_n_a, bwe_n_b;
  logic [31:0] do0_a, do0_b, do1_a, do1_b;
  logic        busy0, busy1, coll0, coll1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dp_ram_sc_bw #(.DW(32), .AW(9), .BW(8), .RD_MODE(0), .OUT_REG(0), .CLR_ON_RST(1)) u0 (
    .CLK(clk), .RST(rst), .A_A(a_a), .A_B(a_b), .DI_A(di_a), .DI_B(di_b),
    .CE_N_A(ce_n_a), .CE_N_B(ce_n_b), .GWE_N_A(gwe_n_a), .GWE_N_B(gwe_n_b),
    .BWE_N_A(bwe_n_a), .BWE_N_B(bwe_n_b), .OE_N_A(oe_n_a), .OE_N_B(oe_n_b),
    .DO_A(do0_a), .DO_B(do0_b), .INIT_BUSY(busy0), .COLL(coll0));

  dp_ram_sc_bw #(.DW(32), .AW(4), .BW(8), .RD_MODE(1), .OUT_REG(1), .CLR_ON_RST(1)) u1 (
    .CLK(clk), .RST(rst), .A_A(a_a[3:0]), .A_B(a_b[3:0]), .DI_A(di_a), .DI_B(di_b),
    .CE_N_A(ce_n_a), .CE_N_B(ce_n_b), .GWE_N_A(gwe_n_a), .GWE_N_B(gwe_n_b),
    .BWE_N_A(bwe_n_a), .BWE_N_B(bwe_n_b), .OE_N_A(oe_n_a), .OE_N_B(oe_n_b),
    .DO_A(do1_a), .DO_B(do1_b), .INIT_BUSY(busy1), .COLL(coll1));

  typedef struct {
    logic        ce_a, we_a, oe_a;
    logic [3:0]  be_a;
    logic [8:0]  ad_a;
    logic [31:0] d_a;
    logic        ce_b, we_b, oe_b;
    logic [3:0]  be_b;
    logic [8:0]  ad_b;
    logic [31:0] d_b;
    logic [31:0] e0a, e0b, e1a, e1b;
    logic        ecoll;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl [NV];

  function automatic vec_t mk(
      input logic ce_a, input logic we_a, input logic [3:0] be_a, input logic [8:0] ad_a,
      input logic [31:0] d_a, input logic oe_a,
      input logic ce_b, input logic we_b, input logic [3:0] be_b, input logic [8:0] ad_b,
      input logic [31:0] d_b, input logic oe_b,
      input logic [31:0] e0a, input logic [31:0] e0b, input logic [31:0] e1a,
      input logic [31:0] e1b, input logic ecoll);
    vec_t v;
    v.ce_a = ce_a; v.we_a = we_a; v.be_a = be_a; v.ad_a = ad_a; v.d_a = d_a; v.oe_a = oe_a;
    v.ce_b = ce_b; v.we_b = we_b; v.be_b = be_b; v.ad_b = ad_b; v.d_b = d_b; v.oe_b = oe_b;
    v.e0a = e0a; v.e0b = e0b; v.e1a = e1a; v.e1b = e1b; v.ecoll = ecoll;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_idle();
    ce_n_a = 1'b1; gwe_n_a = 1'b1; bwe_n_a = 4'hF; a_a = '0; di_a = '0; oe_n_a = 1'b0;
    ce_n_b = 1'b1; gwe_n_b = 1'b1; bwe_n_b = 4'hF; a_b = '0; di_b = '0; oe_n_b = 1'b0;
  endtask

  // Called at the negedge where RST was just released. Counts, per instance,
  // the cycles (sampled before each edge) during which INIT_BUSY is high.
  task automatic run_clear(input bit attempt, output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    for (int k = 1; k <= 700; k++) begin
      if (busy0) c0++;
      if (busy1) c1++;
      if (!busy0 && !busy1) break;
      set_idle();
      if (attempt && k == 10) begin
        ce_n_a = 1'b0; gwe_n_a = 1'b0; bwe_n_a = 4'h0; a_a = 9'h003; di_a = 32'h12345678;
      end
      if (attempt && k == 11) begin
        ce_n_a = 1'b0; a_a = 9'h1F0;
      end
      if (attempt && k == 13) begin
        check("busy_read_ignored u0", do0_a, 32'h0);
        check("busy_read_ignored u1", do1_a, 32'h0);
      end
      @(posedge clk);
      @(negedge clk);
    end
    set_idle();
  endtask

  initial begin
    int c0, c1;

    //            ---------- port A ----------------------  ---------- port B ----------------------  u0 A         u0 B         u1 A         u1 B         coll
    tbl[0]  = mk(0,0,4'h0,9'h010,32'h11223344,0, 1,1,4'hF,9'h000,32'h0,0,        32'h0,       32'h0,       32'h0,       32'h0,       0);
    tbl[1]  = mk(1,1,4'hF,9'h000,32'h0,0,        0,0,4'hA,9'h010,32'hAABBCCDD,0, 32'h0,       32'h11223344,32'h11223344,32'h0,       0);
    tbl[2]  = mk(0,1,4'hF,9'h010,32'h0,0,        1,1,4'hF,9'h000,32'h0,0,        32'h11BB33DD,32'h11223344,32'h11223344,32'h11BB33DD,0);
    tbl[3]  = mk(1,1,4'hF,9'h000,32'h0,0,        1,1,4'hF,9'h000,32'h0,0,        32'h11BB33DD,32'h11223344,32'h11BB33DD,32'h11BB33DD,0);
    tbl[4]  = mk(0,0,4'hC,9'h1FF,32'hFFFF0000,0, 0,0,4'h0,9'h1FF,32'h12345678,0, 32'h0,       32'h0,       32'h11BB33DD,32'h11BB33DD,1);
    tbl[5]  = mk(0,1,4'hF,9'h1FF,32'h0,0,        1,1,4'hF,9'h000,32'h0,0,        32'h12340000,32'h0,       32'h0,       32'h12345678,0);
    tbl[6]  = mk(1,1,4'hF,9'h000,32'h0,0,        0,1,4'hF,9'h1FF,32'h0,0,        32'h12340000,32'h12340000,32'h12340000,32'h12345678,0);
    tbl[7]  = mk(0,0,4'h0,9'h020,32'hDEADBEEF,0, 1,1,4'hF,9'h000,32'h0,0,        32'h0,       32'h12340000,32'h12340000,32'h12340000,0);
    tbl[8]  = mk(0,1,4'hF,9'h020,32'h0,0,        0,0,4'h0,9'h020,32'hCAFEF00D,0, 32'hDEADBEEF,32'hDEADBEEF,32'hDEADBEEF,32'h12340000,1);
    tbl[9]  = mk(0,1,4'hF,9'h020,32'h0,0,        1,1,4'hF,9'h000,32'h0,0,        32'hCAFEF00D,32'hDEADBEEF,32'hDEADBEEF,32'hCAFEF00D,0);
    tbl[10] = mk(1,1,4'hF,9'h000,32'h0,0,        1,1,4'hF,9'h000,32'h0,0,        32'hCAFEF00D,32'hDEADBEEF,32'hCAFEF00D,32'hCAFEF00D,0);
    tbl[11] = mk(0,0,4'hE,9'h005,32'h000000FF,0, 1,1,4'hF,9'h000,32'h0,0,        32'h0,       32'hDEADBEEF,32'hCAFEF00D,32'hCAFEF00D,0);
    tbl[12] = mk(1,1,4'hF,9'h000,32'h0,1,        1,1,4'hF,9'h000,32'h0,1,        32'h0,       32'h0,       32'h0,       32'h0,       0);
    tbl[13] = mk(1,1,4'hF,9'h000,32'h0,0,        1,1,4'hF,9'h000,32'h0,0,        32'h0,       32'hDEADBEEF,32'h000000FF,32'hCAFEF00D,0);
    tbl[14] = mk(0,0,4'hF,9'h010,32'h12345678,0, 1,1,4'hF,9'h000,32'h0,0,        32'h0,       32'hDEADBEEF,32'h000000FF,32'hCAFEF00D,0);
    tbl[15] = mk(0,1,4'hF,9'h010,32'h0,0,        1,1,4'hF,9'h000,32'h0,0,        32'h11BB33DD,32'hDEADBEEF,32'hCAFEF00D,32'hCAFEF00D,0);
    tbl[16] = mk(0,1,4'hF,9'h1FF,32'h0,0,        0,1,4'hF,9'h1FF,32'h0,0,        32'h12340000,32'h12340000,32'hCAFEF00D,32'hCAFEF00D,0);
    tbl[17] = mk(1,1,4'hF,9'h000,32'h0,0,        1,1,4'hF,9'h000,32'h0,0,        32'h12340000,32'h12340000,32'h12340000,32'h12340000,0);
    tbl[18] = mk(0,0,4'h0,9'h030,32'h00000001,0, 0,0,4'h0,9'h031,32'h00000002,0, 32'h0,       32'h0,       32'h12340000,32'h12340000,0);
    tbl[19] = mk(0,1,4'hF,9'h031,32'h0,0,        0,1,4'hF,9'h030,32'h0,0,        32'h2,       32'h1,       32'h1,       32'h2,       0);
    tbl[20] = mk(1,1,4'hF,9'h000,32'h0,0,        1,1,4'hF,9'h000,32'h0,0,        32'h2,       32'h1,       32'h2,       32'h1,       0);

    set_idle();

    // Reset state while RST is held
    repeat (2) @(posedge clk);
    #1;
    check("rst do0_a", do0_a, 32'h0);
    check("rst do0_b", do0_b, 32'h0);
    check("rst do1_a", do1_a, 32'h0);
    check("rst do1_b", do1_b, 32'h0);
    check("rst coll0", {31'b0, coll0}, 32'h0);
    check("rst coll1", {31'b0, coll1}, 32'h0);
    check("rst busy0", {31'b0, busy0}, 32'h1);
    check("rst busy1", {31'b0, busy1}, 32'h1);

    @(negedge clk);
    rst = 1'b0;
    run_clear(1'b0, c0, c1);
    check("first clear cycles u0", c0, 512);
    check("first clear cycles u1", c1, 16);

    // Preload every word, then pulse RST and clear again
    for (int i = 0; i < 512; i++) begin
      ce_n_a = 1'b0; gwe_n_a = 1'b0; bwe_n_a = 4'h0; a_a = 9'(i); di_a = 32'hA5A5A5A5;
      @(negedge clk);
    end
    set_idle();
    rst = 1'b1;
    @(negedge clk);
    check("rst held busy1", {31'b0, busy1}, 32'h1);
    rst = 1'b0;
    run_clear(1'b1, c0, c1);
    check("clear cycles u0", c0, 512);
    check("clear cycles u1", c1, 16);

    // Read back words 0..15 (both) and 0x1F0 (u0), first read right after busy falls
    for (int i = 0; i <= 17; i++) begin
      set_idle();
      if (i <= 16) begin
        ce_n_a = 1'b0;
        a_a    = (i < 16) ? 9'(i) : 9'h1F0;
      end
      @(posedge clk);
      #1;
      if (i <= 16) check($sformatf("clear u0 rd%0d", i), do0_a, 32'h0);
      if (i >= 1)  check($sformatf("clear u1 rd%0d", i - 1), do1_a, 32'h0);
      @(negedge clk);
    end
    set_idle();

    // Directed table
    for (int r = 0; r < NV; r++) begin
      ce_n_a = tbl[r].ce_a; gwe_n_a = tbl[r].we_a; bwe_n_a = tbl[r].be_a;
      a_a = tbl[r].ad_a; di_a = tbl[r].d_a; oe_n_a = tbl[r].oe_a;
      ce_n_b = tbl[r].ce_b; gwe_n_b = tbl[r].we_b; bwe_n_b = tbl[r].be_b;
      a_b = tbl[r].ad_b; di_b = tbl[r].d_b; oe_n_b = tbl[r].oe_b;
      @(posedge clk);
      #1;
      check($sformatf("row%0d do0_a", r), do0_a, tbl[r].e0a);
      check($sformatf("row%0d do0_b", r), do0_b, tbl[r].e0b);
      check($sformatf("row%0d do1_a", r), do1_a, tbl[r].e1a);
      check($sformatf("row%0d do1_b", r), do1_b, tbl[r].e1b);
      check($sformatf("row%0d coll0", r), {31'b0, coll0}, {31'b0, tbl[r].ecoll});
      check($sformatf("row%0d coll1", r), {31'b0, coll1}, {31'b0, tbl[r].ecoll});
      @(negedge clk);
    end
    set_idle();

    // Reset in the middle of a clear: abort at counter 7, then a full restart
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    check("midclr busy1 before", {31'b0, busy1}, 32'h1);
    rst = 1'b1;
    #1;
    check("midclr busy0", {31'b0, busy0}, 32'h1);
    check("midclr busy1", {31'b0, busy1}, 32'h1);
    check("midclr do0_a", do0_a, 32'h0);
    check("midclr do1_a", do1_a, 32'h0);
    check("midclr do0_b", do0_b, 32'h0);
    check("midclr do1_b", do1_b, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_clear(1'b0, c0, c1);
    check("restart clear cycles u0", c0, 512);
    check("restart clear cycles u1", c1, 16);

    // Words written by the table are gone after the restarted clear
    ce_n_a = 1'b0; a_a = 9'h010;
    ce_n_b = 1'b0; a_b = 9'h1FF;
    @(posedge clk);
    #1;
    check("post clear u0 0x010", do0_a, 32'h0);
    check("post clear u0 0x1FF", do0_b, 32'h0);
    @(negedge clk);
    set_idle();
    @(posedge clk);
    #1;
    check("post clear u1 0x0", do1_a, 32'h0);
    check("post clear u1 0xF", do1_b, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
